// File: rtl/mbus_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mbus_responder_pkg
//  Description : Shared definitions for the M_BUS memory responder: state
//                encoding, default bus widths and wait-state limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package mbus_responder_pkg;

    // Default bus widths
    localparam int c_DATA_W   = 16;
    localparam int c_ADDR_W   = 16;

    // Wait-state limits; the counter is wide enough for the maximum
    localparam int c_WAIT_MAX = 15;
    localparam int c_CNT_W    = 4;

    // State encoding shared with the controller
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = c_ST_IDLE,
        ACCESS = c_ST_ACCESS,
        WAIT   = c_ST_WAIT,
        RESP   = c_ST_RESP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mbus_wait_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mbus_wait_cnt
//  Description : Loadable down-counter with zero flag used to time memory
//                wait states. Load has priority over decrement; the count
//                stops at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mbus_wait_cnt
    import mbus_responder_pkg::*;
#(
    parameter int WIDTH = c_CNT_W
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Count register: load wins, otherwise decrement down to zero
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mbus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mbus_responder
//  Description : Memory-side driver of the controller M_BUS. Accepts single
//                read/write requests, sequences memory strobes with a
//                programmable number of wait states and returns read data on
//                M_BUS together with the MIS load strobe. All outputs are
//                registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module mbus_responder
    import mbus_responder_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int ADDR_W      = c_ADDR_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_RE,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] M_BUS,
    output logic              MIS,
    output logic              DONE,
    output logic              BUSY
);

    // Reject illegal wait-state settings at elaboration
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > c_WAIT_MAX)) begin : g_wait_range_err
        $error("mbus_responder: WAIT_CYCLES out of range 0..15");
    end

    // Counter is loaded with WAIT_CYCLES-1 so WAIT lasts WAIT_CYCLES cycles
    localparam int               c_WAIT_LOAD_I = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_WAIT_LOAD_I[c_CNT_W-1:0];

    state_t            r_state;
    state_t            w_state_next;

    // Request latches
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Wait counter handshake
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;

    // Request view for the access cycle: live inputs on the accepting edge
    logic              w_acc_we;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;

    // Next values of the output registers
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_re;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_m_bus;
    logic              w_mis;
    logic              w_done;
    logic              w_busy;

    assign w_cnt_load = (r_state == ACCESS);
    assign w_cnt_dec  = (r_state == WAIT);

    mbus_wait_cnt #(
        .WIDTH (c_CNT_W)
    ) u_wait_cnt (
        .CLK        (CLK),
        .CLR        (CLR),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_load_val (c_WAIT_LOAD),
        .o_zero     (w_cnt_zero)
    );

    // State register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one access, optional wait, one response, back to idle
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (REQ) w_state_next = ACCESS;
            ACCESS:  w_state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (w_cnt_zero) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Latch the request on the accepting edge only; later input changes are ignored
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && REQ) begin
            r_we    <= WE;
            r_addr  <= ADDR;
            r_wdata <= WDATA;
        end
    end

    assign w_acc_we    = (r_state == IDLE) ? WE    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? ADDR  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? WDATA : r_wdata;

    // Output decode for the state being entered, so outputs can be registered
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_m_bus     = '0;
        w_mis       = 1'b0;
        w_done      = 1'b0;
        w_busy      = (w_state_next != IDLE);
        unique case (w_state_next)
            ACCESS: begin
                w_mem_addr  = w_acc_addr;
                w_mem_re    = ~w_acc_we;
                w_mem_we    = w_acc_we;
                w_mem_wdata = w_acc_we ? w_acc_wdata : '0;
            end
            WAIT: begin
                w_mem_addr  = r_addr;
                w_mem_re    = ~r_we;
            end
            RESP: begin
                w_done      = 1'b1;
                w_mis       = ~r_we;
                w_m_bus     = r_we ? '0 : MEM_RDATA;
            end
            default: begin
            end
        endcase
    end

    // Output registers; read data is captured on the edge entering RESP
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_RE    <= 1'b0;
            MEM_WE    <= 1'b0;
            M_BUS     <= '0;
            MIS       <= 1'b0;
            DONE      <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            MEM_ADDR  <= w_mem_addr;
            MEM_WDATA <= w_mem_wdata;
            MEM_RE    <= w_mem_re;
            MEM_WE    <= w_mem_we;
            M_BUS     <= w_m_bus;
            MIS       <= w_mis;
            DONE      <= w_done;
            BUSY      <= w_busy;
        end
    end

endmodule
`default_nettype wire
